alu_rs: RTL and testbench

Reservation station (issue queue) directly upstream of the integer ALU in the out-of-order core. Holds dispatched ALU micro-ops until both source operands are available, captures operand values broadcast on the common data bus (CDB), and issues the oldest ready micro-op each cycle. Its registered issue outputs map one-to-one onto the ALU input bundle (rs1, rs2, imm, ALUSrc, ALUCtrl, valid) plus a destination tag for writeback.

---
 rtl/alu_rs.sv | 116 +++++++++++
 tb/tb_alu_rs.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station; collapsing age-ordered queue (slot 0 oldest) with CDB wakeup, oldest-ready select into registered iss_* outputs, and direct issue of an already-ready dispatch; disp_ready/rs_count come from registered state.
module alu_rs #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [3:0]               disp_ctrl,
  input  logic                     disp_alusrc,
  input  logic [31:0]              disp_imm,
  input  logic                     disp_src1_rdy,
  input  logic                     disp_src2_rdy,
  input  logic [TAG_W-1:0]         disp_src1_tag,
  input  logic [TAG_W-1:0]         disp_src2_tag,
  input  logic [31:0]              disp_src1_val,
  input  logic [31:0]              disp_src2_val,
  input  logic [TAG_W-1:0]         disp_dest_tag,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [31:0]              cdb_val,
  output logic                     iss_valid,
  output logic [3:0]               iss_ctrl,
  output logic                     iss_alusrc,
  output logic [31:0]              iss_rs1,
  output logic [31:0]              iss_rs2,
  output logic [31:0]              iss_imm,
  output logic [TAG_W-1:0]         iss_dest_tag,
  output logic [$clog2(DEPTH):0]   rs_count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  typedef struct packed {
    logic [3:0]       ctrl;
    logic             alusrc;
    logic [31:0]      imm;
    logic             r1;
    logic [TAG_W-1:0] t1;
    logic [31:0]      v1;
    logic             r2;
    logic [TAG_W-1:0] t2;
    logic [31:0]      v2;
    logic [TAG_W-1:0] dest;
  } ent_t;
  ent_t ent [DEPTH];
  ent_t w [DEPTH+1];
  ent_t nx [DEPTH];
  ent_t d;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] sel, pos;
  logic found, direct, accept, hit1, hit2;
  assign rs_count   = cnt;
  assign disp_ready = cnt < CW'(DEPTH);
  assign accept     = disp_valid && disp_ready;
  // A dispatch whose operands were ready on arrival skips the queue when nothing older is ready;
  // a CDB-bypassed operand still takes the normal wakeup path.
  assign direct     = accept && !found && disp_src1_rdy && (disp_src2_rdy || disp_alusrc);
  assign hit1       = !disp_src1_rdy && cdb_valid && cdb_tag == disp_src1_tag;
  assign hit2       = !disp_src2_rdy && cdb_valid && cdb_tag == disp_src2_tag;
  assign d = '{ctrl: disp_ctrl, alusrc: disp_alusrc, imm: disp_imm,
               r1: disp_src1_rdy || hit1, t1: disp_src1_tag, v1: hit1 ? cdb_val : disp_src1_val,
               r2: disp_src2_rdy || hit2, t2: disp_src2_tag, v2: hit2 ? cdb_val : disp_src2_val,
               dest: disp_dest_tag};
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (CW'(i) < cnt && ent[i].r1 && (ent[i].r2 || ent[i].alusrc)) begin
        found = 1'b1;
        sel   = IW'(i);
      end
  end
  always_comb begin
    w[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w[i] = ent[i];
      if (cdb_valid && !ent[i].r1 && ent[i].t1 == cdb_tag) begin
        w[i].r1 = 1'b1;
        w[i].v1 = cdb_val;
      end
      if (cdb_valid && !ent[i].r2 && ent[i].t2 == cdb_tag) begin
        w[i].r2 = 1'b1;
        w[i].v2 = cdb_val;
      end
    end
    for (int i = 0; i < DEPTH; i++)
      nx[i] = (found && IW'(i) >= sel) ? w[i+1] : w[i];
    pos = IW'(cnt - CW'(found));
    if (accept && !direct)
      nx[pos] = d;
    cnt_n = cnt + CW'(accept && !direct) - CW'(found);
  end
  always_ff @(posedge clk) begin
    cnt       <= (reset || flush) ? '0 : cnt_n;
    iss_valid <= !reset && !flush && (found || direct);
    for (int i = 0; i < DEPTH; i++)
      ent[i] <= (reset || flush) ? '0 : nx[i];
    if (reset) begin
      iss_ctrl     <= '0;
      iss_alusrc   <= 1'b0;
      iss_rs1      <= '0;
      iss_rs2      <= '0;
      iss_imm      <= '0;
      iss_dest_tag <= '0;
    end else if (!flush && (found || direct)) begin
      iss_ctrl     <= direct ? d.ctrl   : ent[sel].ctrl;
      iss_alusrc   <= direct ? d.alusrc : ent[sel].alusrc;
      iss_rs1      <= direct ? d.v1     : ent[sel].v1;
      iss_rs2      <= direct ? d.v2     : ent[sel].v2;
      iss_imm      <= direct ? d.imm    : ent[sel].imm;
      iss_dest_tag <= direct ? d.dest   : ent[sel].dest;
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed bench for alu_rs covering reset, issue paths, wakeup, full queue, flush and mid-run reset.
module tb_alu_rs;
  localparam int DEPTH = 8;
  localparam int TAG_W = 6;
  logic clk = 1'b0;
  logic reset, flush, disp_valid, disp_ready, disp_alusrc, disp_src1_rdy, disp_src2_rdy;
  logic [3:0] disp_ctrl, iss_ctrl;
  logic [31:0] disp_imm, disp_src1_val, disp_src2_val, cdb_val, iss_rs1, iss_rs2, iss_imm;
  logic [TAG_W-1:0] disp_src1_tag, disp_src2_tag, disp_dest_tag, cdb_tag, iss_dest_tag;
  logic cdb_valid, iss_valid, iss_alusrc;
  logic [$clog2(DEPTH):0] rs_count;
  int nv = 0;
  int nm = 0;
  always #5 clk = ~clk;
  alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ctrl(disp_ctrl),
    .disp_alusrc(disp_alusrc), .disp_imm(disp_imm),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
    .disp_dest_tag(disp_dest_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .iss_valid(iss_valid), .iss_ctrl(iss_ctrl), .iss_alusrc(iss_alusrc),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_imm(iss_imm),
    .iss_dest_tag(iss_dest_tag), .rs_count(rs_count)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush      = 1'b0;
    reset      = 1'b0;
  endtask
  task automatic disp(input logic [3:0] c, input logic a, input logic [31:0] im,
                      input logic r1, input logic [TAG_W-1:0] t1, input logic [31:0] v1,
                      input logic r2, input logic [TAG_W-1:0] t2, input logic [31:0] v2,
                      input logic [TAG_W-1:0] dt);
    disp_valid = 1'b1; disp_ctrl = c; disp_alusrc = a; disp_imm = im;
    disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
    disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
    disp_dest_tag = dt;
  endtask
  task automatic bcast(input logic [TAG_W-1:0] t, input logic [31:0] v);
    cdb_valid = 1'b1; cdb_tag = t; cdb_val = v;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    idle;
    nv++; if ({rs_count, disp_ready, iss_valid} !== {4'd0, 1'b1, 1'b0}) begin nm++; $display("FAIL reset_ctl: got %h expected %h", {rs_count, disp_ready, iss_valid}, {4'd0, 1'b1, 1'b0}); end
    nv++; if ({iss_ctrl, iss_alusrc, iss_rs1, iss_rs2, iss_imm, iss_dest_tag} !== '0) begin nm++; $display("FAIL reset_iss: got %h expected 0", {iss_ctrl, iss_alusrc, iss_rs1, iss_rs2, iss_imm, iss_dest_tag}); end
  endtask
  task automatic test_add;
    disp(4'b0010, 1'b0, 32'd0, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7, 6'd3);
    tick;
    idle;
    nv++; if ({iss_valid, iss_ctrl, iss_dest_tag} !== {1'b1, 4'b0010, 6'd3}) begin nm++; $display("FAIL add_hdr: got %h expected %h", {iss_valid, iss_ctrl, iss_dest_tag}, {1'b1, 4'b0010, 6'd3}); end
    nv++; if ({iss_rs1, iss_rs2} !== {32'd5, 32'd7}) begin nm++; $display("FAIL add_ops: got %h expected %h", {iss_rs1, iss_rs2}, {32'd5, 32'd7}); end
    nv++; if (rs_count !== 4'd0) begin nm++; $display("FAIL add_cnt: got %0d expected 0", rs_count); end
    tick;
    nv++; if (iss_valid !== 1'b0) begin nm++; $display("FAIL add_pulse: got %b expected 0", iss_valid); end
  endtask
  task automatic test_wakeup;
    disp(4'b0110, 1'b0, 32'd0, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd1, 6'd5);
    tick;
    idle;
    nv++; if ({rs_count, iss_valid} !== {4'd1, 1'b0}) begin nm++; $display("FAIL sub_wait: got %h expected %h", {rs_count, iss_valid}, {4'd1, 1'b0}); end
    bcast(6'd9, 32'h10);
    tick;
    idle;
    nv++; if (iss_valid !== 1'b0) begin nm++; $display("FAIL sub_early: got %b expected 0", iss_valid); end
    tick;
    nv++; if ({iss_valid, iss_ctrl, iss_dest_tag, rs_count} !== {1'b1, 4'b0110, 6'd5, 4'd0}) begin nm++; $display("FAIL sub_hdr: got %h expected %h", {iss_valid, iss_ctrl, iss_dest_tag, rs_count}, {1'b1, 4'b0110, 6'd5, 4'd0}); end
    nv++; if ({iss_rs1, iss_rs2} !== {32'h10, 32'd1}) begin nm++; $display("FAIL sub_ops: got %h expected %h", {iss_rs1, iss_rs2}, {32'h10, 32'd1}); end
  endtask
  task automatic test_full;
    for (int i = 0; i < DEPTH; i++) begin
      disp(4'b0010, 1'b0, 32'd0, 1'b0, (i == 2 || i == 5) ? 6'd30 : 6'(20 + i), 32'd0,
           1'b1, 6'd0, 32'(i), 6'(40 + i));
      tick;
    end
    idle;
    nv++; if ({rs_count, disp_ready, iss_valid} !== {4'd8, 1'b0, 1'b0}) begin nm++; $display("FAIL full_state: got %h expected %h", {rs_count, disp_ready, iss_valid}, {4'd8, 1'b0, 1'b0}); end
    disp(4'b0010, 1'b0, 32'd0, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1, 6'd63);
    tick;
    idle;
    nv++; if ({rs_count, iss_valid} !== {4'd8, 1'b0}) begin nm++; $display("FAIL full_reject: got %h expected %h", {rs_count, iss_valid}, {4'd8, 1'b0}); end
    bcast(6'd30, 32'h55);
    tick;
    idle;
    nv++; if ({rs_count, iss_valid} !== {4'd8, 1'b0}) begin nm++; $display("FAIL full_wake: got %h expected %h", {rs_count, iss_valid}, {4'd8, 1'b0}); end
    tick;
    nv++; if ({iss_valid, iss_dest_tag, iss_rs1, iss_rs2, rs_count, disp_ready} !== {1'b1, 6'd42, 32'h55, 32'd2, 4'd7, 1'b1}) begin nm++; $display("FAIL full_first: got %h expected %h", {iss_valid, iss_dest_tag, iss_rs1, iss_rs2, rs_count, disp_ready}, {1'b1, 6'd42, 32'h55, 32'd2, 4'd7, 1'b1}); end
    tick;
    nv++; if ({iss_valid, iss_dest_tag, iss_rs1, iss_rs2, rs_count} !== {1'b1, 6'd45, 32'h55, 32'd5, 4'd6}) begin nm++; $display("FAIL full_second: got %h expected %h", {iss_valid, iss_dest_tag, iss_rs1, iss_rs2, rs_count}, {1'b1, 6'd45, 32'h55, 32'd5, 4'd6}); end
    tick;
    nv++; if (iss_valid !== 1'b0) begin nm++; $display("FAIL full_quiet: got %b expected 0", iss_valid); end
    flush = 1'b1;
    tick;
    idle;
    nv++; if (rs_count !== 4'd0) begin nm++; $display("FAIL full_drain: got %0d expected 0", rs_count); end
  endtask
  task automatic test_imm;
    disp(4'b0011, 1'b1, 32'hFF, 1'b1, 6'd0, 32'h0F, 1'b0, 6'd4, 32'd0, 6'd8);
    tick;
    idle;
    nv++; if ({iss_valid, iss_ctrl, iss_alusrc, iss_dest_tag, rs_count} !== {1'b1, 4'b0011, 1'b1, 6'd8, 4'd0}) begin nm++; $display("FAIL imm_hdr: got %h expected %h", {iss_valid, iss_ctrl, iss_alusrc, iss_dest_tag, rs_count}, {1'b1, 4'b0011, 1'b1, 6'd8, 4'd0}); end
    nv++; if ({iss_imm, iss_rs1} !== {32'hFF, 32'h0F}) begin nm++; $display("FAIL imm_ops: got %h expected %h", {iss_imm, iss_rs1}, {32'hFF, 32'h0F}); end
  endtask
  task automatic test_bypass;
    disp(4'b0010, 1'b0, 32'd0, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'd2, 6'd10);
    bcast(6'd12, 32'hABCD);
    tick;
    idle;
    nv++; if ({rs_count, iss_valid} !== {4'd1, 1'b0}) begin nm++; $display("FAIL byp_wait: got %h expected %h", {rs_count, iss_valid}, {4'd1, 1'b0}); end
    tick;
    nv++; if ({iss_valid, iss_dest_tag, iss_rs1, rs_count} !== {1'b1, 6'd10, 32'hABCD, 4'd0}) begin nm++; $display("FAIL byp_iss: got %h expected %h", {iss_valid, iss_dest_tag, iss_rs1, rs_count}, {1'b1, 6'd10, 32'hABCD, 4'd0}); end
  endtask
  task automatic test_both_tags;
    disp(4'b0000, 1'b0, 32'd0, 1'b0, 6'd7, 32'd0, 1'b0, 6'd7, 32'd0, 6'd11);
    tick;
    idle;
    bcast(6'd7, 32'h99);
    tick;
    idle;
    nv++; if (iss_valid !== 1'b0) begin nm++; $display("FAIL both_early: got %b expected 0", iss_valid); end
    tick;
    nv++; if ({iss_valid, iss_ctrl, iss_dest_tag, iss_rs1, iss_rs2} !== {1'b1, 4'b0000, 6'd11, 32'h99, 32'h99}) begin nm++; $display("FAIL both_iss: got %h expected %h", {iss_valid, iss_ctrl, iss_dest_tag, iss_rs1, iss_rs2}, {1'b1, 4'b0000, 6'd11, 32'h99, 32'h99}); end
  endtask
  task automatic test_back_to_back;
    disp(4'b0001, 1'b0, 32'd0, 1'b0, 6'd60, 32'd0, 1'b1, 6'd0, 32'd3, 6'd12);
    tick;
    idle;
    bcast(6'd60, 32'd1);
    tick;
    idle;
    disp(4'b1110, 1'b0, 32'd0, 1'b0, 6'd61, 32'd0, 1'b1, 6'd0, 32'd4, 6'd13);
    bcast(6'd61, 32'h22);
    tick;
    idle;
    nv++; if ({iss_valid, iss_ctrl, iss_dest_tag, iss_rs1, rs_count} !== {1'b1, 4'b0001, 6'd12, 32'd1, 4'd1}) begin nm++; $display("FAIL b2b_first: got %h expected %h", {iss_valid, iss_ctrl, iss_dest_tag, iss_rs1, rs_count}, {1'b1, 4'b0001, 6'd12, 32'd1, 4'd1}); end
    tick;
    nv++; if ({iss_valid, iss_ctrl, iss_dest_tag, iss_rs1, rs_count} !== {1'b1, 4'b1110, 6'd13, 32'h22, 4'd0}) begin nm++; $display("FAIL b2b_second: got %h expected %h", {iss_valid, iss_ctrl, iss_dest_tag, iss_rs1, rs_count}, {1'b1, 4'b1110, 6'd13, 32'h22, 4'd0}); end
    for (int i = 0; i < 3; i++) begin
      disp(4'b0010, 1'b0, 32'd0, 1'b1, 6'd0, 32'(100 + i), 1'b1, 6'd0, 32'd0, 6'(14 + i));
      tick;
      nv++; if ({iss_valid, iss_dest_tag, iss_rs1, rs_count} !== {1'b1, 6'(14 + i), 32'(100 + i), 4'd0}) begin nm++; $display("FAIL b2b_stream%0d: got %h expected %h", i, {iss_valid, iss_dest_tag, iss_rs1, rs_count}, {1'b1, 6'(14 + i), 32'(100 + i), 4'd0}); end
    end
    idle;
  endtask
  task automatic test_flush;
    for (int i = 0; i < 4; i++) begin
      disp(4'b0010, 1'b0, 32'd0, 1'b0, 6'(50 + i), 32'd0, 1'b1, 6'd0, 32'(i), 6'(20 + i));
      tick;
    end
    idle;
    nv++; if (rs_count !== 4'd4) begin nm++; $display("FAIL fl_fill: got %0d expected 4", rs_count); end
    bcast(6'd50, 32'd7);
    tick;
    idle;
    flush = 1'b1;
    tick;
    idle;
    nv++; if ({rs_count, iss_valid, disp_ready} !== {4'd0, 1'b0, 1'b1}) begin nm++; $display("FAIL fl_clear: got %h expected %h", {rs_count, iss_valid, disp_ready}, {4'd0, 1'b0, 1'b1}); end
    bcast(6'd51, 32'd1);
    tick;
    idle;
    tick;
    nv++; if ({rs_count, iss_valid} !== {4'd0, 1'b0}) begin nm++; $display("FAIL fl_stale: got %h expected %h", {rs_count, iss_valid}, {4'd0, 1'b0}); end
    disp(4'b0010, 1'b0, 32'd0, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1, 6'd30);
    flush = 1'b1;
    tick;
    idle;
    nv++; if ({rs_count, iss_valid} !== {4'd0, 1'b0}) begin nm++; $display("FAIL fl_drop: got %h expected %h", {rs_count, iss_valid}, {4'd0, 1'b0}); end
  endtask
  task automatic test_mid_reset;
    disp(4'b0010, 1'b0, 32'd0, 1'b0, 6'd40, 32'd0, 1'b1, 6'd0, 32'd0, 6'd1);
    tick;
    disp(4'b0110, 1'b0, 32'h3, 1'b1, 6'd0, 32'd8, 1'b1, 6'd0, 32'd9, 6'd2);
    tick;
    idle;
    nv++; if ({iss_valid, iss_dest_tag, rs_count} !== {1'b1, 6'd2, 4'd1}) begin nm++; $display("FAIL mr_pre: got %h expected %h", {iss_valid, iss_dest_tag, rs_count}, {1'b1, 6'd2, 4'd1}); end
    reset = 1'b1;
    bcast(6'd40, 32'd5);
    tick;
    idle;
    nv++; if ({rs_count, disp_ready, iss_valid, iss_ctrl, iss_rs1, iss_rs2, iss_imm, iss_dest_tag} !== {4'd0, 1'b1, 1'b0, 4'd0, 96'd0, 6'd0}) begin nm++; $display("FAIL mr_clear: got %h expected %h", {rs_count, disp_ready, iss_valid, iss_ctrl, iss_rs1, iss_rs2, iss_imm, iss_dest_tag}, {4'd0, 1'b1, 1'b0, 4'd0, 96'd0, 6'd0}); end
    bcast(6'd40, 32'd5);
    tick;
    idle;
    tick;
    nv++; if ({rs_count, iss_valid} !== {4'd0, 1'b0}) begin nm++; $display("FAIL mr_stale: got %h expected %h", {rs_count, iss_valid}, {4'd0, 1'b0}); end
  endtask
  initial begin
    {reset, flush, disp_valid, disp_alusrc, disp_src1_rdy, disp_src2_rdy, cdb_valid} = '0;
    {disp_ctrl, disp_imm, disp_src1_val, disp_src2_val, cdb_val} = '0;
    {disp_src1_tag, disp_src2_tag, disp_dest_tag, cdb_tag} = '0;
    test_reset;
    test_add;
    test_wakeup;
    test_full;
    test_imm;
    test_bypass;
    test_both_tags;
    test_back_to_back;
    test_flush;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", nv, nm);
    $finish;
  end
endmodule
